// File: rtl/gray_desel_pkg.sv
// Shared widths, slot range and frame-end phase for the gray feedback deselector.
package gray_desel_pkg;
  localparam int PHASE_W    = 11;
  localparam int WORD_W     = 10;
  localparam int SLOT_W     = 4;
  localparam int SLOT_FIRST = 1;
  localparam int SLOT_LAST  = 10;

  localparam logic [PHASE_W-1:0] FRAME_END = 11'd2047;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [SLOT_W-1:0]  slot_t;
endpackage

// File: rtl/gray_slot_dec.sv
// Trailing-ones decoder: the slot is the gray bit that toggles on the edge where
// the phase counter holds n.
module gray_slot_dec
  import gray_desel_pkg::*;
(
  input  logic [PHASE_W-1:0] n_i,
  output logic [SLOT_W-1:0]  slot_o
);

  // Scan downward so the last hit is the lowest zero bit; all-ones yields PHASE_W.
  always_comb begin
    slot_o = SLOT_W'(PHASE_W);
    for (int i = PHASE_W - 1; i >= 0; i--) begin
      if (!n_i[i]) slot_o = SLOT_W'(i);
    end
  end

endmodule

// File: rtl/gray_deselector_fb.sv
// Rebuilds the 10-bit counter word from the gray-multiplexed feedback stream.
// Optional slot-consistency checking is enabled by GRAY_DESEL_ERRCHK_EN.
module gray_deselector_fb
  import gray_desel_pkg::*;
(
  input  logic              clk_ext,
  input  logic              rst_ext,
  input  logic              sync_clr,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid,
  output logic [SLOT_W-1:0] slot_o,
  output logic              err_o
);

  phase_t            n_q;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  slot_t             slot;
  logic [SLOT_W-1:0] sh_idx;
  logic              sample_en;
  logic              frame_end;

  gray_slot_dec u_slot_dec (
    .n_i    (n_q),
    .slot_o (slot)
  );

  assign slot_o     = slot;
  assign sample_en  = (slot >= SLOT_W'(SLOT_FIRST)) && (slot <= SLOT_W'(SLOT_LAST));
  // Slot 1 lands in the word MSB, slot 10 in the LSB.
  assign sh_idx     = SLOT_W'(SLOT_LAST) - slot;
  assign frame_end  = (n_q == FRAME_END);
  assign word_o     = word_q;
  assign word_valid = valid_q;

  always_comb begin
    shadow_d = shadow_q;
    if (sample_en) shadow_d[sh_idx] = bit_in;
  end

  always_ff @(posedge clk_ext or posedge rst_ext) begin
    if (rst_ext) begin
      n_q      <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else if (sync_clr) begin
      n_q      <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      n_q      <= n_q + 1'b1;
      shadow_q <= shadow_d;
      valid_q  <= frame_end;
      if (frame_end) word_q <= shadow_q;
    end
  end

`ifdef GRAY_DESEL_ERRCHK_EN
  logic [WORD_W-1:0] seen_q, seen_d;
  logic [WORD_W-1:0] ref_q, ref_d;
  logic              ferr_q, ferr_d;
  logic              err_q;

  // First sample of a slot is the reference; any later disagreement flags the frame.
  always_comb begin
    seen_d = seen_q;
    ref_d  = ref_q;
    ferr_d = ferr_q;
    if (sample_en) begin
      if (!seen_q[sh_idx]) begin
        seen_d[sh_idx] = 1'b1;
        ref_d[sh_idx]  = bit_in;
      end else if (ref_q[sh_idx] != bit_in) begin
        ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ext or posedge rst_ext) begin
    if (rst_ext) begin
      seen_q <= '0;
      ref_q  <= '0;
      ferr_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (sync_clr) begin
      seen_q <= '0;
      ferr_q <= 1'b0;
    end else if (frame_end) begin
      seen_q <= '0;
      ferr_q <= 1'b0;
      err_q  <= ferr_q;
    end else begin
      seen_q <= seen_d;
      ref_q  <= ref_d;
      ferr_q <= ferr_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_deselector_fb.sv
// Directed bench for gray_deselector_fb with a frame-level reference model;
// expected err_o follows GRAY_DESEL_ERRCHK_EN.
module tb_gray_deselector_fb;

`ifdef GRAY_DESEL_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic       clk_ext = 1'b0;
  logic       rst_ext;
  logic       sync_clr;
  logic       bit_in;
  logic [9:0] word_o;
  logic       word_valid;
  logic [3:0] slot_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  gray_deselector_fb dut (
    .clk_ext    (clk_ext),
    .rst_ext    (rst_ext),
    .sync_clr   (sync_clr),
    .bit_in     (bit_in),
    .word_o     (word_o),
    .word_valid (word_valid),
    .slot_o     (slot_o),
    .err_o      (err_o)
  );

  always #5 clk_ext = ~clk_ext;

  // Slot k fires when n mod 2^(k+1) == 2^k - 1.
  function automatic int slot_of(input int n);
    for (int k = 0; k <= 11; k++) begin
      if ((n % (2 << k)) == ((1 << k) - 1)) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model state
  int         m_n;
  logic [9:0] m_word;
  bit         m_valid, m_err, m_ferr;
  bit         m_seen[12];
  bit         m_ref[12];
  bit         m_last[12];

  // Stimulus state
  logic [9:0] cur_word;
  int         inj_n;

  always @(posedge clk_ext or posedge rst_ext) begin
    int k;
    if (rst_ext) begin
      m_n = 0; m_word = '0; m_valid = 0; m_err = 0; m_ferr = 0;
      for (int i = 0; i < 12; i++) begin m_seen[i] = 0; m_ref[i] = 0; m_last[i] = 0; end
    end else if (sync_clr) begin
      m_n = 0; m_valid = 0; m_ferr = 0;
      for (int i = 0; i < 12; i++) begin m_seen[i] = 0; m_last[i] = 0; end
    end else begin
      k = slot_of(m_n);
      if (k >= 1 && k <= 10) begin
        if (!m_seen[k]) begin
          m_seen[k] = 1;
          m_ref[k]  = bit_in;
        end else if (m_ref[k] != bit_in) begin
          m_ferr = 1;
        end
        m_last[k] = bit_in;
      end
      if (m_n == 2047) begin
        for (int j = 1; j <= 10; j++) m_word[10-j] = m_last[j];
        m_err   = ERRCHK ? m_ferr : 1'b0;
        m_valid = 1;
        m_ferr  = 0;
        for (int i = 0; i < 12; i++) m_seen[i] = 0;
      end else begin
        m_valid = 0;
      end
      m_n = (m_n + 1) % 2048;
    end
  end

  // Transmitter stand-in: non-data slots carry noise that must never be captured.
  always @(negedge clk_ext) begin
    int k;
    k = slot_of(m_n);
    if (k >= 1 && k <= 10) bit_in = cur_word[10-k] ^ (m_n == inj_n);
    else bit_in = 1'($urandom_range(0, 1));
  end

  always @(negedge clk_ext) begin
    chk("cyc_word_o", 32'(word_o), 32'(m_word));
    chk("cyc_word_valid", 32'(word_valid), 32'(m_valid));
    chk("cyc_err_o", 32'(err_o), 32'(m_err));
    chk("cyc_slot_o", 32'(slot_o), 32'(slot_of(m_n)));
  end

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_ext);
      cyc++;
    end while (word_valid !== 1'b1 && cyc < 3000);
    if (word_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s timeout actual=no_valid required=valid_within_3000", name);
    end
  endtask

  task automatic wait_phase(input int target);
    int guard;
    guard = 0;
    while (m_n != target && guard < 3000) begin
      @(negedge clk_ext);
      guard++;
    end
    chk("phase_reached", 32'(m_n), 32'(target));
  endtask

  initial begin
    int c;
    int c10, c11, p10, p11, s;
    rst_ext  = 1'b1;
    sync_clr = 1'b0;
    bit_in   = 1'b0;
    cur_word = 10'h2A5;
    inj_n    = -1;
    repeat (3) @(negedge clk_ext);
    chk("rst_word", 32'(word_o), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_slot", 32'(slot_o), 32'd0);
    rst_ext = 1'b0;

    wait_valid("first", c);
    chk("first_latency", 32'(c), 32'd2048);
    chk("first_word", 32'(word_o), 32'h2A5);
    chk("first_err", 32'(err_o), 32'd0);

    cur_word = 10'h3FF;
    wait_valid("ones", c);
    chk("ones_period", 32'(c), 32'd2048);
    chk("ones_word", 32'(word_o), 32'h3FF);

    cur_word = 10'h000;
    wait_valid("zeros", c);
    chk("zeros_period", 32'(c), 32'd2048);
    chk("zeros_word", 32'(word_o), 32'h000);

    // First slot-1 sample at or after n=100 is n=101 (101 mod 4 == 1).
    cur_word = 10'h2A5;
    inj_n    = 101;
    wait_valid("inject", c);
    chk("inject_period", 32'(c), 32'd2048);
    chk("inject_word", 32'(word_o), 32'h2A5);
    chk("inject_err", 32'(err_o), 32'(ERRCHK));
    inj_n = -1;
    wait_valid("clean", c);
    chk("clean_err", 32'(err_o), 32'd0);
    chk("clean_word", 32'(word_o), 32'h2A5);

    cur_word = 10'h15A;
    wait_phase(700);
    sync_clr = 1'b1;
    @(negedge clk_ext);
    sync_clr = 1'b0;
    chk("sync_hold_word", 32'(word_o), 32'h2A5);
    chk("sync_valid", 32'(word_valid), 32'd0);
    wait_valid("sync", c);
    chk("sync_latency", 32'(c), 32'd2048);
    chk("sync_word", 32'(word_o), 32'h15A);

    wait_phase(1500);
    #2 rst_ext = 1'b1;
    #1;
    chk("arst_word", 32'(word_o), 32'd0);
    chk("arst_valid", 32'(word_valid), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    chk("arst_slot", 32'(slot_o), 32'd0);
    repeat (2) @(negedge clk_ext);
    rst_ext = 1'b0;
    wait_valid("post_rst", c);
    chk("post_rst_latency", 32'(c), 32'd2048);
    chk("post_rst_word", 32'(word_o), 32'h15A);

    c10 = 0; c11 = 0; p10 = -1; p11 = -1;
    for (int i = 0; i < 2048; i++) begin
      s = int'(slot_o);
      if ((m_n % 2) == 0) chk("sweep_even", 32'(s), 32'd0);
      if (s == 11) begin c11++; p11 = m_n; end
      if (s == 10) begin c10++; p10 = m_n; end
      @(negedge clk_ext);
    end
    chk("sweep_cnt11", 32'(c11), 32'd1);
    chk("sweep_pos11", 32'(p11), 32'd2047);
    chk("sweep_cnt10", 32'(c10), 32'd1);
    chk("sweep_pos10", 32'(p10), 32'd1023);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
